pipelined_adder: RTL

Parametrised, pipelined integer adder/subtractor with a valid/ready handshake, for the multi-cycle and pipelined core variants where a full-width single-cycle carry chain limits clock frequency. It splits a DATA_WIDTH operation into STAGES carry-chained slices, one per register stage. It supports ADD, SUB and RV64-style word ops (ADDW/SUBW), passes a tag through for writeback, and produces carry, overflow and zero flags.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_slice.sv | 23 ++
 rtl/pipelined_adder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation encoding,
// op-decode helpers and default widths.
package adder_pkg;

    typedef enum logic [1:0] {
        ADD_OP  = 2'b00,
        SUB_OP  = 2'b01,
        ADDW_OP = 2'b10,
        SUBW_OP = 2'b11
    } adder_op_e;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_STAGES     = 4;
    localparam int DEFAULT_TAG_WIDTH  = 5;

    // Subtraction is a + ~b + 1, so bit 0 of the op is both "invert B" and carry-in.
    function automatic logic is_sub(input adder_op_e op);
        return op[0];
    endfunction

    // Word ops work on the low half and sign-extend it to full width.
    function automatic logic is_word(input adder_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational WIDTH-bit adder slice with carry in and carry out.
// One slice is evaluated per pipeline stage of pipelined_adder.
module adder_slice #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0] total;

    // One extra bit on the sum catches the carry out of the slice.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    end

    assign sum       = total[WIDTH-1:0];
    assign carry_out = total[WIDTH];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor with valid/ready handshake. The operation is
// split into STAGES carry-chained slices, one slice summed per register stage.
// Optional flag logic (carry/overflow/zero) is enabled by defining the macro
// PIPELINED_ADDER_FLAGS_EN; without it the flags read 0 and no flag state exists.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int STAGES     = DEFAULT_STAGES,
    parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    output logic                  o_valid,
    input  logic                  i_res_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [TAG_WIDTH-1:0]  o_tag,
    output logic                  o_carry,
    output logic                  o_overflow,
    output logic                  o_zero
);

    localparam int SLICE_W = DATA_WIDTH / STAGES;
    localparam int HALF_W  = DATA_WIDTH / 2;
    localparam int LAST    = STAGES - 1;

    if ((DATA_WIDTH % STAGES) != 0 || (DATA_WIDTH % 2) != 0) begin : g_bad_params
        $error("pipelined_adder: DATA_WIDTH must be even and divisible by STAGES");
    end

    // Slice-k input view: either the raw operation (k=0) or stage register k-1.
    logic [DATA_WIDTH-1:0] in_a     [STAGES];
    logic [DATA_WIDTH-1:0] in_b     [STAGES];
    logic [DATA_WIDTH-1:0] in_sum   [STAGES];
    logic                  in_carry [STAGES];
    adder_op_e             in_op    [STAGES];
    logic [TAG_WIDTH-1:0]  in_tag   [STAGES];

    logic [SLICE_W-1:0]    slice_sum  [STAGES];
    logic                  slice_cout [STAGES];

    // Stage register k holds the result of slices 0..k.
    logic                  valid_d [STAGES], valid_q [STAGES];
    logic [DATA_WIDTH-1:0] a_d     [STAGES], a_q     [STAGES];
    logic [DATA_WIDTH-1:0] b_d     [STAGES], b_q     [STAGES];
    logic [DATA_WIDTH-1:0] sum_d   [STAGES], sum_q   [STAGES];
    logic                  carry_d [STAGES], carry_q [STAGES];
    adder_op_e             op_d    [STAGES], op_q    [STAGES];
    logic [TAG_WIDTH-1:0]  tag_d   [STAGES], tag_q   [STAGES];

`ifdef PIPELINED_ADDER_FLAGS_EN
    // Carries into the bits that define the flags, captured once the slice
    // holding each bit has been summed: [0] into bit DATA_WIDTH-1,
    // [1] into bit HALF_W-1, [2] into bit HALF_W (the word carry out).
    localparam int CB_TOP = 0;
    localparam int CB_WLO = 1;
    localparam int CB_WHI = 2;
    logic [2:0] in_cbits [STAGES];
    logic [2:0] cbits_d  [STAGES], cbits_q [STAGES];
`endif

    logic      en;
    adder_op_e op_in;
    logic      sub_in;

    assign en      = ~valid_q[LAST] | i_res_ready;
    assign o_ready = en;
    assign op_in   = adder_op_e'(i_op);
    assign sub_in  = is_sub(op_in);

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign in_a[0]     = i_operand_a;
            assign in_b[0]     = sub_in ? ~i_operand_b : i_operand_b;
            assign in_sum[0]   = '0;
            assign in_carry[0] = sub_in;
            assign in_op[0]    = op_in;
            assign in_tag[0]   = i_tag;
`ifdef PIPELINED_ADDER_FLAGS_EN
            assign in_cbits[0] = '0;
`endif
        end else begin : g_link
            assign in_a[k]     = a_q[k-1];
            assign in_b[k]     = b_q[k-1];
            assign in_sum[k]   = sum_q[k-1];
            assign in_carry[k] = carry_q[k-1];
            assign in_op[k]    = op_q[k-1];
            assign in_tag[k]   = tag_q[k-1];
`ifdef PIPELINED_ADDER_FLAGS_EN
            assign in_cbits[k] = cbits_q[k-1];
`endif
        end

        adder_slice #(.WIDTH(SLICE_W)) u_slice (
            .a         (in_a[k][k*SLICE_W +: SLICE_W]),
            .b         (in_b[k][k*SLICE_W +: SLICE_W]),
            .carry_in  (in_carry[k]),
            .sum       (slice_sum[k]),
            .carry_out (slice_cout[k])
        );
    end

    // Next-state of every stage: merge the new slice sum, or hold everything on stall.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = in_sum[k];
            sum_d[k][k*SLICE_W +: SLICE_W] = slice_sum[k];
            a_d[k]     = in_a[k];
            b_d[k]     = in_b[k];
            carry_d[k] = slice_cout[k];
            op_d[k]    = in_op[k];
            tag_d[k]   = in_tag[k];
`ifdef PIPELINED_ADDER_FLAGS_EN
            cbits_d[k] = in_cbits[k];
            if ((DATA_WIDTH - 1) / SLICE_W == k) begin
                cbits_d[k][CB_TOP] = sum_d[k][DATA_WIDTH-1] ^ in_a[k][DATA_WIDTH-1]
                                   ^ in_b[k][DATA_WIDTH-1];
            end
            if ((HALF_W - 1) / SLICE_W == k) begin
                cbits_d[k][CB_WLO] = sum_d[k][HALF_W-1] ^ in_a[k][HALF_W-1] ^ in_b[k][HALF_W-1];
            end
            if (HALF_W / SLICE_W == k) begin
                cbits_d[k][CB_WHI] = sum_d[k][HALF_W] ^ in_a[k][HALF_W] ^ in_b[k][HALF_W];
            end
`endif
        end
        if (!en) begin
            sum_d   = sum_q;
            a_d     = a_q;
            b_d     = b_q;
            carry_d = carry_q;
            op_d    = op_q;
            tag_d   = tag_q;
`ifdef PIPELINED_ADDER_FLAGS_EN
            cbits_d = cbits_q;
`endif
        end
    end

    // Valid bits: flush wins over everything, then advance on en, else hold.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
        end
        if (i_flush) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_d[k] = 1'b0;
            end
        end else if (en) begin
            valid_d[0] = i_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    // Only the valid bits need reset; data is gated at the outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data path registers, unreset.
    always_ff @(posedge i_clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
        op_q    <= op_d;
        tag_q   <= tag_d;
`ifdef PIPELINED_ADDER_FLAGS_EN
        cbits_q <= cbits_d;
`endif
    end

    // Result and tag from the last stage, forced to zero when nothing is valid.
    always_comb begin
        o_valid  = valid_q[LAST];
        o_result = '0;
        o_tag    = '0;
        if (valid_q[LAST]) begin
            o_tag = tag_q[LAST];
            if (is_word(op_q[LAST])) begin
                o_result = {{HALF_W{sum_q[LAST][HALF_W-1]}}, sum_q[LAST][HALF_W-1:0]};
            end else begin
                o_result = sum_q[LAST];
            end
        end
    end

`ifdef PIPELINED_ADDER_FLAGS_EN
    // Flags at the effective width of the operation held in the last stage.
    always_comb begin
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        o_zero     = 1'b0;
        if (valid_q[LAST]) begin
            if (is_word(op_q[LAST])) begin
                o_carry    = cbits_q[LAST][CB_WHI];
                o_overflow = cbits_q[LAST][CB_WLO] ^ cbits_q[LAST][CB_WHI];
                o_zero     = (sum_q[LAST][HALF_W-1:0] == '0);
            end else begin
                o_carry    = carry_q[LAST];
                o_overflow = cbits_q[LAST][CB_TOP] ^ carry_q[LAST];
                o_zero     = (sum_q[LAST] == '0);
            end
        end
    end
`else
    assign o_carry    = 1'b0;
    assign o_overflow = 1'b0;
    assign o_zero     = 1'b0;
`endif

endmodule
